// File: rtl/generic_pkt_fifo.sv
// rtl/generic_pkt_fifo.sv - single-clock packet FIFO with commit/rewind on packet boundaries
// Optional statistics outputs (pkt_cnt, drop_cnt) when GENERIC_PKT_FIFO_STATS_EN is defined.
module generic_pkt_fifo #(
  parameter int DWIDTH    = 64,
  parameter int AWIDTH    = 9,
  parameter int AF_MARGIN = 16
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25_n,
  input  logic              wen,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              wsop,
  input  logic              weop,
  input  logic              werr,
  output logic              full,
  output logic              almost_full,
  input  logic              ren,
  output logic [DWIDTH-1:0] rdata,
  output logic              rsop,
  output logic              reop,
  output logic              rvalid,
  output logic              empty,
  output logic [AWIDTH:0]   level,
  output logic              drop_pulse,
  output logic              ovf_pulse
`ifdef GENERIC_PKT_FIFO_STATS_EN
  ,
  output logic [31:0]       pkt_cnt,
  output logic [31:0]       drop_cnt
`endif
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH+1:0] DEPTH_EXT = (AWIDTH+2)'(DEPTH);
  localparam logic [AWIDTH+1:0] AF_EXT    = (AWIDTH+2)'(AF_MARGIN);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IN_PKT  = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [DWIDTH+1:0] mem [DEPTH];

  logic [AWIDTH:0]   wr_ptr, cmt_ptr, rd_ptr;
  logic [AWIDTH:0]   wr_ptr_nxt, cmt_ptr_nxt;
  logic [AWIDTH:0]   used;
  logic [AWIDTH+1:0] free_words;
  logic [1:0]        state, state_nxt;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic              start_pkt;
  logic              drop_nxt, ovf_nxt;
  logic              rd_en;

  // wr_ptr counts speculative words, so full/almost_full include the open packet
  assign used        = wr_ptr - rd_ptr;
  assign free_words  = DEPTH_EXT - {1'b0, used};
  assign full        = (used == DEPTH_EXT[AWIDTH:0]);
  assign almost_full = (free_words <= AF_EXT);
  assign level       = cmt_ptr - rd_ptr;
  assign empty       = (level == '0);
  assign rd_en       = ren & ~empty;

  // Write-side decisions: a new packet always starts at cmt_ptr, which also covers the abort case
  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    cmt_ptr_nxt = cmt_ptr;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr[AWIDTH-1:0];
    start_pkt   = 1'b0;
    drop_nxt    = 1'b0;
    ovf_nxt     = 1'b0;
    case (state)
      ST_IDLE, ST_IN_PKT: begin
        if (wen) begin
          if (full) begin
            wr_ptr_nxt = cmt_ptr;
            ovf_nxt    = 1'b1;
            drop_nxt   = 1'b1;
            state_nxt  = ST_DISCARD;
          end else if (wsop) begin
            start_pkt = 1'b1;
            drop_nxt  = (state == ST_IN_PKT);
          end else if (state == ST_IDLE) begin
            drop_nxt = 1'b1;
          end else begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (weop) begin
              state_nxt = ST_IDLE;
              if (werr) begin
                wr_ptr_nxt = cmt_ptr;
                drop_nxt   = 1'b1;
              end else begin
                cmt_ptr_nxt = wr_ptr + 1'b1;
              end
            end
          end
        end
      end
      ST_DISCARD: begin
        if (wen) begin
          if (wsop && !full) begin
            start_pkt = 1'b1;
          end else if (weop) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (start_pkt) begin
      mem_we     = 1'b1;
      mem_waddr  = cmt_ptr[AWIDTH-1:0];
      wr_ptr_nxt = cmt_ptr + 1'b1;
      state_nxt  = ST_IN_PKT;
      if (weop) begin
        state_nxt = ST_IDLE;
        if (werr) begin
          wr_ptr_nxt = cmt_ptr;
          drop_nxt   = 1'b1;
        end else begin
          cmt_ptr_nxt = cmt_ptr + 1'b1;
        end
      end
    end
  end

  // Storage write; contents deliberately survive reset
  always_ff @(posedge clk_156m25) begin
    if (mem_we) begin
      mem[mem_waddr] <= {wsop, weop, wdata};
    end
  end

  // Pointer, FSM and event pulse registers
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      wr_ptr     <= '0;
      cmt_ptr    <= '0;
      rd_ptr     <= '0;
      state      <= ST_IDLE;
      drop_pulse <= 1'b0;
      ovf_pulse  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      cmt_ptr    <= cmt_ptr_nxt;
      state      <= state_nxt;
      drop_pulse <= drop_nxt;
      ovf_pulse  <= ovf_nxt;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Registered read port; rdata/rsop/reop hold their last value between reads
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      rdata  <= '0;
      rsop   <= 1'b0;
      reop   <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        {rsop, reop, rdata} <= mem[rd_ptr[AWIDTH-1:0]];
      end
    end
  end

`ifdef GENERIC_PKT_FIFO_STATS_EN
  // Saturating counters of committed and discarded packets
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if ((cmt_ptr_nxt != cmt_ptr) && (pkt_cnt != '1)) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      if (drop_nxt && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_generic_pkt_fifo.sv
// tb/tb_generic_pkt_fifo.sv - randomized self-checking bench for generic_pkt_fifo
module tb_generic_pkt_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFM   = 4;

  typedef logic [DW+1:0] word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wen, wsop, weop, werr, ren;
  logic [DW-1:0] wdata;
  logic          full, almost_full, rsop, reop, rvalid, empty, drop_pulse, ovf_pulse;
  logic [DW-1:0] rdata;
  logic [AW:0]   level;
`ifdef GENERIC_PKT_FIFO_STATS_EN
  logic [31:0]   pkt_cnt, drop_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: committed words, the open packet, and the writer's mode
  word_t cq[$];
  word_t pend[$];
  int    mode;
  logic  exp_rvalid, exp_drop, exp_ovf;
  word_t exp_word;

  always #5 clk = ~clk;

  generic_pkt_fifo #(.DWIDTH(DW), .AWIDTH(AW), .AF_MARGIN(AFM)) dut (
    .clk_156m25(clk), .reset_156m25_n(rst_n),
    .wen(wen), .wdata(wdata), .wsop(wsop), .weop(weop), .werr(werr),
    .full(full), .almost_full(almost_full),
    .ren(ren), .rdata(rdata), .rsop(rsop), .reop(reop), .rvalid(rvalid),
    .empty(empty), .level(level), .drop_pulse(drop_pulse), .ovf_pulse(ovf_pulse)
`ifdef GENERIC_PKT_FIFO_STATS_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  task automatic apply_reset();
    wen = 0; wsop = 0; weop = 0; werr = 0; ren = 0; wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cq.delete(); pend.delete(); mode = 0;
    exp_rvalid = 0; exp_drop = 0; exp_ovf = 0;
  endtask

  task automatic end_pkt(input logic er);
    if (er) begin
      exp_drop = 1;
    end else begin
      foreach (pend[i]) cq.push_back(pend[i]);
    end
    pend.delete();
    mode = 0;
  endtask

  // Drive one cycle and advance the model (mode 0 idle, 1 in packet, 2 discarding)
  task automatic step(input logic w, s, e, er, input logic [DW-1:0] d, input logic r);
    bit    m_full;
    bit    start;
    word_t wd;
    wen = w; wsop = s; weop = e; werr = er; wdata = d; ren = r;
    m_full = (cq.size() + pend.size() == DEPTH);
    @(posedge clk);
    exp_rvalid = 0; exp_drop = 0; exp_ovf = 0; start = 0;
    if (r && cq.size() != 0) begin
      exp_rvalid = 1;
      exp_word   = cq.pop_front();
    end
    if (w) begin
      wd = {s, e, d};
      if (mode != 2 && m_full) begin
        pend.delete(); exp_ovf = 1; exp_drop = 1; mode = 2;
      end else if (mode == 2) begin
        if (s && !m_full) start = 1;
        else if (e) mode = 0;
      end else if (s) begin
        if (mode == 1) exp_drop = 1;
        start = 1;
      end else if (mode == 0) begin
        exp_drop = 1;
      end else begin
        pend.push_back(wd);
        if (e) end_pkt(er);
      end
      if (start) begin
        pend.delete();
        pend.push_back(wd);
        mode = 1;
        if (e) end_pkt(er);
      end
    end
    #1;
    wen = 0; wsop = 0; weop = 0; werr = 0; ren = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %0b exp 1", empty); end
    tests_run++; if (level !== '0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", level); end
    tests_run++; if ({full, almost_full, rvalid, rsop, reop} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags got %05b exp 00000", {full, almost_full, rvalid, rsop, reop}); end
    tests_run++; if ({drop_pulse, ovf_pulse} !== 2'b0 || rdata !== '0) begin tests_failed++; $display("FAIL reset_pulse_rdata got %02b/%0h exp 00/0", {drop_pulse, ovf_pulse}, rdata); end
  endtask

  task automatic test_basic_packet();
    logic [DW-1:0] d [4];
    apply_reset();
    foreach (d[i]) d[i] = DW'($urandom);
    for (int i = 0; i < 4; i++) begin
      step(1, i == 0, i == 3, 0, d[i], 0);
      if (i < 3) begin
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL basic_empty_w%0d got %0b exp 1", i, empty); end
      end
    end
    tests_run++; if (level !== 5'd4 || empty !== 1'b0) begin tests_failed++; $display("FAIL basic_level got %0d/%0b exp 4/0", level, empty); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, '0, 1);
      tests_run++;
      if ({rvalid, rsop, reop, rdata} !== {1'b1, i == 0, i == 3, d[i]}) begin
        tests_failed++;
        $display("FAIL basic_read%0d got v%0b s%0b e%0b %0h exp v1 s%0b e%0b %0h", i, rvalid, rsop, reop, rdata, i == 0, i == 3, d[i]);
      end
    end
    step(0, 0, 0, 0, '0, 1);
    tests_run++; if (rvalid !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL basic_read_empty got v%0b e%0b exp v0 e1", rvalid, empty); end
  endtask

  task automatic test_error_drop();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1, i == 0, i == 2, i == 2, DW'($urandom), 0);
    tests_run++; if (drop_pulse !== 1'b1 || level !== '0) begin tests_failed++; $display("FAIL err_drop got drop%0b lvl%0d exp drop1 lvl0", drop_pulse, level); end
    step(0, 0, 0, 0, '0, 0);
    tests_run++; if (drop_pulse !== 1'b0 || almost_full !== 1'b0 || full !== 1'b0) begin tests_failed++; $display("FAIL err_after got drop%0b af%0b f%0b exp 000", drop_pulse, almost_full, full); end
    for (int i = 0; i < 2; i++) step(1, i == 0, i == 1, 0, DW'($urandom), 0);
    tests_run++; if (int'(level) !== 2) begin tests_failed++; $display("FAIL err_good_level got %0d exp 2", level); end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, '0, 1);
      tests_run++; if (rvalid !== 1'b1 || {rsop, reop, rdata} !== exp_word) begin tests_failed++; $display("FAIL err_good_read%0d got %0b %0h exp 1 %0h", i, rvalid, {rsop, reop, rdata}, exp_word); end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1, i == 1, 0, 0, DW'(i), 0);
      if (i == 11) begin
        tests_run++; if (almost_full !== 1'b0) begin tests_failed++; $display("FAIL ovf_af11 got %0b exp 0", almost_full); end
      end
      if (i == 12) begin
        tests_run++; if (almost_full !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("FAIL ovf_af12 got af%0b f%0b exp af1 f0", almost_full, full); end
      end
    end
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full16 got %0b exp 1", full); end
    step(1, 0, 0, 0, DW'(17), 0);
    tests_run++; if ({ovf_pulse, drop_pulse, full, almost_full} !== 4'b1100) begin tests_failed++; $display("FAIL ovf_hit got %04b exp 1100", {ovf_pulse, drop_pulse, full, almost_full}); end
    step(1, 0, 0, 0, DW'(18), 0);
    step(1, 0, 1, 0, DW'(19), 0);
    tests_run++; if (level !== '0 || ovf_pulse !== 1'b0 || drop_pulse !== 1'b0) begin tests_failed++; $display("FAIL ovf_discard got lvl%0d ovf%0b drop%0b exp 0 0 0", level, ovf_pulse, drop_pulse); end
    step(1, 1, 1, 0, DW'(20), 0);
    tests_run++; if (int'(level) !== 1) begin tests_failed++; $display("FAIL ovf_recover got %0d exp 1", level); end
  endtask

  task automatic test_abort();
    logic [DW-1:0] d [3];
    apply_reset();
    foreach (d[i]) d[i] = DW'($urandom);
    step(1, 1, 0, 0, DW'($urandom), 0);
    step(1, 0, 0, 0, DW'($urandom), 0);
    step(1, 1, 0, 0, d[0], 0);
    tests_run++; if (drop_pulse !== 1'b1) begin tests_failed++; $display("FAIL abort_drop got %0b exp 1", drop_pulse); end
    step(1, 0, 0, 0, d[1], 0);
    step(1, 0, 1, 0, d[2], 0);
    tests_run++; if (int'(level) !== 3) begin tests_failed++; $display("FAIL abort_level got %0d exp 3", level); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, '0, 1);
      tests_run++;
      if ({rvalid, rsop, reop, rdata} !== {1'b1, i == 0, i == 2, d[i]}) begin
        tests_failed++;
        $display("FAIL abort_read%0d got %0b%0b%0b %0h exp 1%0b%0b %0h", i, rvalid, rsop, reop, rdata, i == 0, i == 2, d[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW+1:0] sent[$];
    logic [DW+1:0] w;
    logic [DW-1:0] d;
    int  got = 0;
    bit  full_seen = 0;
    apply_reset();
    for (int c = 0; c < 210; c++) begin
      if (c < 200) begin
        d = DW'($urandom);
        sent.push_back({(c % 5) == 0, (c % 5) == 4, d});
        step(1, (c % 5) == 0, (c % 5) == 4, 0, d, cq.size() != 0);
      end else begin
        step(0, 0, 0, 0, '0, cq.size() != 0);
      end
      full_seen |= full;
      if (rvalid) begin
        got++;
        w = (sent.size() != 0) ? sent.pop_front() : '0;
        tests_run++; if ({rsop, reop, rdata} !== w) begin tests_failed++; $display("FAIL b2b_data%0d got %0h exp %0h", got, {rsop, reop, rdata}, w); end
      end
    end
    tests_run++; if (got !== 200) begin tests_failed++; $display("FAIL b2b_count got %0d exp 200", got); end
    tests_run++; if (full_seen !== 1'b0) begin tests_failed++; $display("FAIL b2b_full got %0b exp 0", full_seen); end
  endtask

  task automatic test_random();
    int free_w;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(5, 0) == 0, $urandom_range(4, 0) == 0,
           $urandom_range(7, 0) == 0, DW'($urandom), $urandom_range(2, 0) == 0);
      free_w = DEPTH - cq.size() - pend.size();
      tests_run++; if (rvalid !== exp_rvalid) begin tests_failed++; $display("FAIL rnd_rvalid c%0d got %0b exp %0b", c, rvalid, exp_rvalid); end
      if (exp_rvalid) begin
        tests_run++; if ({rsop, reop, rdata} !== exp_word) begin tests_failed++; $display("FAIL rnd_rdata c%0d got %0h exp %0h", c, {rsop, reop, rdata}, exp_word); end
      end
      tests_run++; if ({drop_pulse, ovf_pulse} !== {exp_drop, exp_ovf}) begin tests_failed++; $display("FAIL rnd_pulses c%0d got %02b exp %0b%0b", c, {drop_pulse, ovf_pulse}, exp_drop, exp_ovf); end
      tests_run++; if (int'(level) !== cq.size() || empty !== (cq.size() == 0)) begin tests_failed++; $display("FAIL rnd_level c%0d got %0d/%0b exp %0d", c, level, empty, cq.size()); end
      tests_run++; if (full !== (free_w == 0) || almost_full !== (free_w <= AFM)) begin tests_failed++; $display("FAIL rnd_fill c%0d got f%0b af%0b exp free %0d", c, full, almost_full, free_w); end
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    for (int i = 0; i < 2; i++) step(1, i == 0, i == 1, 0, DW'($urandom), 0);
    step(1, 1, 0, 0, DW'($urandom), 0);
    #1 rst_n = 1'b0;
    #2;
    tests_run++; if (level !== '0 || empty !== 1'b1 || almost_full !== 1'b0) begin tests_failed++; $display("FAIL midrst got lvl%0d e%0b af%0b exp 0 1 0", level, empty, almost_full); end
`ifdef GENERIC_PKT_FIFO_STATS_EN
    tests_run++; if (pkt_cnt !== 32'd0 || drop_cnt !== 32'd0) begin tests_failed++; $display("FAIL midrst_stats got %0d/%0d exp 0/0", pkt_cnt, drop_cnt); end
`endif
    apply_reset();
  endtask

`ifdef GENERIC_PKT_FIFO_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 2; i++) step(1, i == 0, i == 1, (i == 1) && (p == 1 || p == 3), DW'($urandom), 0);
    end
    step(0, 0, 0, 0, '0, 0);
    tests_run++; if (pkt_cnt !== 32'd3 || drop_cnt !== 32'd2) begin tests_failed++; $display("FAIL stats got %0d/%0d exp 3/2", pkt_cnt, drop_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_packet();
    test_error_drop();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef GENERIC_PKT_FIFO_STATS_EN
    test_stats();
`endif
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
